adder_pipe: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. It is the multi-cycle successor to the team's 4-bit ripple adder. The block splits a WIDTH-bit add or subtract into STAGES equal chunks and registers the carry between chunks, which keeps the carry path short at any width. A valid/ready handshake with a global stall lets it sit directly between streaming producers and consumers in the datapath.

---
 rtl/adder_pkg.sv | 9 +
 rtl/adder_pipe_if.sv | 25 ++
 rtl/adder_chunk.sv | 20 ++
 rtl/full_adder.sv | 11 +
 rtl/adder_pipe.sv | 100 ++++++++++
 tb/tb_adder_pipe.sv | 223 ++++++++++++++++++++++
 6 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined adder: elaboration-time legality of the
// WIDTH/STAGES pair.
package adder_pkg;

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (width >= 2) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Operand/result stream bundle for adder_pipe. master = producer+consumer side,
// slave = the adder itself.
interface adder_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, x, y, sub, cin, out_ready,
    input  in_ready, out_valid, sum, carry, overflow
  );

  modport slave (
    input  in_valid, x, y, sub, cin, out_ready,
    output in_ready, out_valid, sum, carry, overflow
  );
endinterface

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple adder built from full_adder cells.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end

  assign co = c[W];
endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry registered
// between slices, global stall when the result is not taken.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  adder_pipe_if.slave  io
);
  localparam int CHUNK = WIDTH / STAGES;

  // a_rem/b_rem shift down one chunk per stage; sum_lo fills in from the top,
  // so after the last stage it holds the full result in place.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_lo;
    logic             c;
    logic             sa;
    logic             sb;
  } stage_t;

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("adder_pipe: WIDTH must be >= 2 and a multiple of STAGES >= 1");
  end

  stage_t entry;
  stage_t pipe [STAGES];
  stage_t last;
  logic   stall;

  assign last        = pipe[STAGES-1];
  assign stall       = last.valid && !io.out_ready;
  assign io.in_ready = !stall;

  always_comb begin
    entry        = '0;
    entry.valid  = io.in_valid;
    entry.a_rem  = io.x;
    entry.b_rem  = io.y ^ {WIDTH{io.sub}};
    entry.c      = io.sub | io.cin;
    entry.sa     = io.x[WIDTH-1];
    entry.sb     = entry.b_rem[WIDTH-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           src;
    stage_t           st_d;
    stage_t           st_q;
    logic [CHUNK-1:0] cs;
    logic             co;

    if (k == 0) begin : g_first
      assign src = entry;
    end else begin : g_rest
      assign src = pipe[k-1];
    end

    adder_chunk #(.W(CHUNK)) u_chunk (
      .a (src.a_rem[CHUNK-1:0]),
      .b (src.b_rem[CHUNK-1:0]),
      .ci(src.c),
      .s (cs),
      .co(co)
    );

    // Bubbles advance the valid bit only; data holds so outputs keep
    // their last value while out_valid is low.
    always_comb begin
      st_d = st_q;
      if (!stall) begin
        st_d.valid = src.valid;
        if (src.valid) begin
          st_d.a_rem  = src.a_rem >> CHUNK;
          st_d.b_rem  = src.b_rem >> CHUNK;
          st_d.sum_lo = (src.sum_lo >> CHUNK) | (WIDTH'(cs) << (WIDTH - CHUNK));
          st_d.c      = co;
          st_d.sa     = src.sa;
          st_d.sb     = src.sb;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) st_q <= '0;
      else     st_q <= st_d;
    end

    assign pipe[k] = st_q;
  end

  assign io.out_valid = last.valid;
  assign io.sum       = last.sum_lo;
  assign io.carry     = last.c;
  assign io.overflow  = (last.sa == last.sb) && (last.sum_lo[WIDTH-1] != last.sa);
endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed table, stalled stream, mid-stream reset and
// a STAGES sweep against an arithmetic reference model.
module tb_adder_pipe;
  localparam int W = 16;
  localparam int SW_N = 200;
  localparam int SW_LAT [3] = '{1, 2, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  adder_pipe_if #(.WIDTH(W)) m_if ();
  adder_pipe_if #(.WIDTH(W)) s1_if ();
  adder_pipe_if #(.WIDTH(W)) s2_if ();
  adder_pipe_if #(.WIDTH(W)) s16_if ();

  adder_pipe #(.WIDTH(W), .STAGES(4))  u_dut (.clk(clk), .rst(rst), .io(m_if.slave));
  adder_pipe #(.WIDTH(W), .STAGES(1))  u_s1  (.clk(clk), .rst(rst), .io(s1_if.slave));
  adder_pipe #(.WIDTH(W), .STAGES(2))  u_s2  (.clk(clk), .rst(rst), .io(s2_if.slave));
  adder_pipe #(.WIDTH(W), .STAGES(16)) u_s16 (.clk(clk), .rst(rst), .io(s16_if.slave));

  logic        sw_v   [3];
  logic [17:0] sw_res [3];
  assign sw_v[0]   = s1_if.out_valid;
  assign sw_v[1]   = s2_if.out_valid;
  assign sw_v[2]   = s16_if.out_valid;
  assign sw_res[0] = {s1_if.carry,  s1_if.overflow,  s1_if.sum};
  assign sw_res[1] = {s2_if.carry,  s2_if.overflow,  s2_if.sum};
  assign sw_res[2] = {s16_if.carry, s16_if.overflow, s16_if.sum};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: {carry, overflow, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic s, input logic ci);
    logic [15:0] r;
    logic [15:0] bb;
    logic        c;
    logic        v;
    if (s) begin
      r = a - b;
      c = (a >= b);
    end else begin
      r = a + b + 16'(ci);
      c = (int'(a) + int'(b) + int'(ci)) > 65535;
    end
    bb = s ? ~b : b;
    v  = (a[15] == bb[15]) && (r[15] != a[15]);
    return {c, v, r};
  endfunction

  task automatic drive_sw(input logic v, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic ci);
    s1_if.in_valid  = v; s1_if.x  = a; s1_if.y  = b; s1_if.sub  = s; s1_if.cin  = ci;
    s2_if.in_valid  = v; s2_if.x  = a; s2_if.y  = b; s2_if.sub  = s; s2_if.cin  = ci;
    s16_if.in_valid = v; s16_if.x = a; s16_if.y = b; s16_if.sub = s; s16_if.cin = ci;
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        c;
    logic        v;
  } vec_t;

  vec_t        tbl [6];
  logic [17:0] expq [$];
  logic        hv [SW_N];
  logic [17:0] hr [SW_N];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          sent;
    int          recv;
    int          cyc;
    logic        pend;
    logic [15:0] px;
    logic [15:0] py;
    logic        ps;
    logic        pc;

    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2346, 1'b0, 1'b0};

    m_if.in_valid = 1'b0; m_if.x = '0; m_if.y = '0; m_if.sub = 1'b0; m_if.cin = 1'b0;
    m_if.out_ready = 1'b1;
    drive_sw(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    s1_if.out_ready = 1'b1; s2_if.out_ready = 1'b1; s16_if.out_ready = 1'b1;

    // Reset state
    @(negedge clk); #1;
    check("rst_out_valid", m_if.out_valid, 0);
    check("rst_in_ready",  m_if.in_ready, 1);
    check("rst_outputs",   {m_if.carry, m_if.overflow, m_if.sum}, 0);
    rst = 1'b0;

    // Directed table, one beat at a time, latency 4
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m_if.in_valid = 1'b1; m_if.x = tbl[i].x; m_if.y = tbl[i].y;
      m_if.sub = tbl[i].sub; m_if.cin = tbl[i].cin;
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk);
        if (j == 1) m_if.in_valid = 1'b0;
        #1;
        if (j == 3) check($sformatf("tbl%0d_early", i), m_if.out_valid, 0);
        if (j == 4) begin
          check($sformatf("tbl%0d_valid", i), m_if.out_valid, 1);
          check($sformatf("tbl%0d_result", i), {m_if.carry, m_if.overflow, m_if.sum},
                {tbl[i].c, tbl[i].v, tbl[i].sum});
        end
      end
    end
    @(negedge clk); #1;
    check("hold_valid", m_if.out_valid, 0);
    check("hold_sum", m_if.sum, tbl[5].sum);

    // Back-to-back random stream with a 3-cycle consumer stall
    sent = 0; recv = 0; cyc = 0; pend = 1'b0;
    px = '0; py = '0; ps = 1'b0; pc = 1'b0;
    while (recv < 8 && cyc < 100) begin
      @(negedge clk);
      if (!pend && sent < 8) begin
        px = 16'($urandom); py = 16'($urandom);
        ps = 1'($urandom); pc = 1'($urandom);
        pend = 1'b1;
      end
      m_if.in_valid = pend; m_if.x = px; m_if.y = py; m_if.sub = ps; m_if.cin = pc;
      m_if.out_ready = !(cyc >= 5 && cyc <= 7);
      #1;
      if (!m_if.out_ready && m_if.out_valid)
        check("stall_in_ready", m_if.in_ready, 0);
      if (m_if.in_valid && m_if.in_ready) begin
        expq.push_back(ref_add(px, py, ps, pc));
        sent++;
        pend = 1'b0;
      end
      if (m_if.out_valid && m_if.out_ready) begin
        if (expq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL stream_extra: got %h, expected no beat",
                   {m_if.carry, m_if.overflow, m_if.sum});
        end else begin
          check($sformatf("stream_res%0d", recv), {m_if.carry, m_if.overflow, m_if.sum},
                expq.pop_front());
        end
        recv++;
      end
      cyc++;
    end
    m_if.in_valid = 1'b0; m_if.out_ready = 1'b1;
    check("stream_count", recv, 8);
    check("stream_leftover", expq.size(), 0);

    // Reset with 3 beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_if.in_valid = 1'b1; m_if.x = 16'($urandom) | 16'h0101; m_if.y = 16'($urandom);
      m_if.sub = 1'b0; m_if.cin = 1'b1;
    end
    @(negedge clk);
    m_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", m_if.out_valid, 0);
    check("midrst_outputs", {m_if.carry, m_if.overflow, m_if.sum}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      check($sformatf("postrst%0d_valid", j), m_if.out_valid, 0);
      check($sformatf("postrst%0d_outputs", j), {m_if.carry, m_if.overflow, m_if.sum}, 0);
      check($sformatf("postrst%0d_ready", j), m_if.in_ready, 1);
    end

    // STAGES sweep: latency and results per instance
    for (int c = 0; c < SW_N; c++) begin
      logic        v;
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic        ci;
      @(negedge clk);
      v = ($urandom_range(0, 3) != 0);
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom); ci = 1'($urandom);
      drive_sw(v, a, b, s, ci);
      hv[c] = v;
      hr[c] = ref_add(a, b, s, ci);
      #1;
      for (int i = 0; i < 3; i++) begin
        logic ev;
        ev = (c >= SW_LAT[i]) ? hv[c - SW_LAT[i]] : 1'b0;
        check($sformatf("sw%0d_valid_c%0d", SW_LAT[i], c), sw_v[i], ev);
        if (ev)
          check($sformatf("sw%0d_res_c%0d", SW_LAT[i], c), sw_res[i], hr[c - SW_LAT[i]]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
